// File: rtl/ifu_fetch_pkg.sv
// Shared widths, hold-level encodings, NOP encoding and FSM state type
// for the instruction-fetch stage.
package ifu_fetch_pkg;

  localparam int InstAddrBus   = 32;
  localparam int InstBus       = 32;
  localparam int Hold_Flag_Bus = 3;

  typedef logic [Hold_Flag_Bus-1:0] hold_flag_t;

  localparam hold_flag_t Hold_None = 3'd0;
  localparam hold_flag_t Hold_Pc   = 3'd1;
  localparam hold_flag_t Hold_If   = 3'd2;
  localparam hold_flag_t Hold_Id   = 3'd3;

  // addi x0, x0, 0
  localparam logic [InstBus-1:0] INST_NOP = 32'h0000_0013;

  localparam logic RstEnable  = 1'b1;
  localparam logic JumpEnable = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } fetch_state_e;

  // Any hold level from Hold_If upward freezes the IF/ID boundary.
  function automatic logic holds_if_stage(input hold_flag_t level);
    return level >= Hold_If;
  endfunction

endpackage

// File: rtl/ifu_skid_buf.sv
// One-entry {data, addr, valid} holding register that parks a fetch
// response arriving while the IF/ID boundary is held.
module ifu_skid_buf
  import ifu_fetch_pkg::*;
#(
  parameter int ADDR_W = InstAddrBus,
  parameter int DATA_W = InstBus
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              load,
  input  logic              unload,
  input  logic [DATA_W-1:0] load_data,
  input  logic [ADDR_W-1:0] load_addr,
  output logic [DATA_W-1:0] data,
  output logic [ADDR_W-1:0] addr,
  output logic              valid
);

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of every other flop.
  always_ff @(posedge clk) begin
    if (rst == RstEnable || clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
    end else if (unload) begin
      valid <= 1'b0;
    end
  end

  // NOTE: the payload carries no reset; valid alone says whether it means anything.
  always_ff @(posedge clk) begin
    if (load) begin
      data <= load_data;
      addr <= load_addr;
    end
  end

endmodule

// File: rtl/ifu_fetch.sv
// Instruction-fetch stage: one bus read per PC, delivers {inst, addr, valid}
// to IF/ID and stalls the PC until each instruction has been delivered.
module ifu_fetch
  import ifu_fetch_pkg::*;
#(
  parameter int              ADDR_W   = InstAddrBus,
  parameter int              DATA_W   = InstBus,
  parameter logic [DATA_W-1:0] NOP_INST = INST_NOP
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [ADDR_W-1:0]        pc_i,
  input  logic                     jump_flag_i,
  input  logic [Hold_Flag_Bus-1:0] hold_flag_i,
  output logic                     ibus_req_o,
  output logic [ADDR_W-1:0]        ibus_addr_o,
  input  logic                     ibus_gnt_i,
  input  logic                     ibus_rvalid_i,
  input  logic [DATA_W-1:0]        ibus_rdata_i,
  output logic [DATA_W-1:0]        inst_o,
  output logic [ADDR_W-1:0]        inst_addr_o,
  output logic                     inst_valid_o,
  output logic                     fetch_stall_o
);

  fetch_state_e state, state_n;

  logic              jump;
  logic              hold_if;
  logic              rsp_live;
  logic              deliver;
  logic              addr_load;
  logic              retarget;
  logic              drop;
  logic              drop_set;
  logic              skid_load;
  logic              skid_unload;
  logic              skid_valid;
  logic [DATA_W-1:0] skid_data;
  logic [ADDR_W-1:0] skid_addr;

  assign jump     = (jump_flag_i == JumpEnable);
  assign hold_if  = holds_if_stage(hold_flag_i);
  assign rsp_live = ibus_rvalid_i && !drop && (state == S_WAIT);

  assign skid_load   = !jump && hold_if && rsp_live;
  assign skid_unload = !jump && !hold_if && skid_valid;

  // The PC may advance only when an instruction actually lands in IF/ID.
  assign deliver       = (rst != RstEnable) && !jump && !hold_if && (skid_valid || rsp_live);
  assign fetch_stall_o = !deliver;

  assign ibus_req_o = (state == S_REQ);

  // A grant that belongs to a flushed fetch must have its response discarded.
  assign drop_set = ((state == S_REQ) && ibus_gnt_i && (jump || retarget)) ||
                    ((state == S_WAIT) && jump && !ibus_rvalid_i);

  ifu_skid_buf #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .clear     (jump),
    .load      (skid_load),
    .unload    (skid_unload),
    .load_data (ibus_rdata_i),
    .load_addr (ibus_addr_o),
    .data      (skid_data),
    .addr      (skid_addr),
    .valid     (skid_valid)
  );

  // NOTE: defaults come first so no path leaves a signal unassigned (no latch).
  always_comb begin
    state_n   = state;
    addr_load = 1'b0;
    case (state)
      S_IDLE: begin
        if (!jump && !skid_valid) begin
          state_n   = S_REQ;
          addr_load = 1'b1;
        end
      end
      S_REQ: begin
        if (ibus_gnt_i) begin
          state_n = S_WAIT;
        end else if (retarget) begin
          addr_load = 1'b1;
        end
      end
      S_WAIT: begin
        if (ibus_rvalid_i) begin
          // A discarded response did not advance the PC, so pc_i is already current.
          if (drop && !jump && !skid_valid) begin
            state_n   = S_REQ;
            addr_load = 1'b1;
          end else begin
            state_n = S_IDLE;
          end
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      state       <= S_IDLE;
      ibus_addr_o <= '0;
      retarget    <= 1'b0;
      // A transaction cut off by reset still returns data; remember to eat it.
      drop        <= (drop || (state == S_WAIT) || ((state == S_REQ) && ibus_gnt_i)) &&
                     !ibus_rvalid_i;
    end else begin
      state    <= state_n;
      retarget <= jump && (state == S_REQ) && !ibus_gnt_i;
      drop     <= (drop && !ibus_rvalid_i) || drop_set;
      if (addr_load) begin
        ibus_addr_o <= pc_i;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      inst_o       <= NOP_INST;
      inst_addr_o  <= '0;
      inst_valid_o <= 1'b0;
    end else if (jump) begin
      inst_o       <= NOP_INST;
      inst_valid_o <= 1'b0;
    end else if (!hold_if) begin
      if (skid_valid) begin
        inst_o       <= skid_data;
        inst_addr_o  <= skid_addr;
        inst_valid_o <= 1'b1;
      end else if (rsp_live) begin
        inst_o       <= ibus_rdata_i;
        inst_addr_o  <= ibus_addr_o;
        inst_valid_o <= 1'b1;
      end else begin
        inst_o       <= NOP_INST;
        inst_valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch: a table of single fetches with varied bus
// wait states and hold levels, plus sequences for flush, hold and reset.
module tb_ifu_fetch;
  import ifu_fetch_pkg::*;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pc_i = '0;
  logic        jump_flag_i = 1'b0;
  logic [2:0]  hold_flag_i = '0;
  logic        ibus_req_o;
  logic [31:0] ibus_addr_o;
  logic        ibus_gnt_i = 1'b0;
  logic        ibus_rvalid_i = 1'b0;
  logic [31:0] ibus_rdata_i = '0;
  logic [31:0] inst_o;
  logic [31:0] inst_addr_o;
  logic        inst_valid_o;
  logic        fetch_stall_o;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ifu_fetch dut (
    .clk           (clk),
    .rst           (rst),
    .pc_i          (pc_i),
    .jump_flag_i   (jump_flag_i),
    .hold_flag_i   (hold_flag_i),
    .ibus_req_o    (ibus_req_o),
    .ibus_addr_o   (ibus_addr_o),
    .ibus_gnt_i    (ibus_gnt_i),
    .ibus_rvalid_i (ibus_rvalid_i),
    .ibus_rdata_i  (ibus_rdata_i),
    .inst_o        (inst_o),
    .inst_addr_o   (inst_addr_o),
    .inst_valid_o  (inst_valid_o),
    .fetch_stall_o (fetch_stall_o)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] rdata;
    int          gd;
    int          rd;
    logic [2:0]  hold;
    logic [31:0] exp_inst;
    logic [31:0] exp_addr;
  } vec_t;

  vec_t vecs[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Entry: FSM idle. Exit: the cycle in which the fetched instruction is visible.
  task automatic do_fetch(input string tag, input logic [31:0] pc, input logic [31:0] data,
                          input int gd, input int rd, input logic [2:0] hold,
                          input logic [31:0] exp_inst, input logic [31:0] exp_addr);
    pc_i        = pc;
    hold_flag_i = hold;
    @(negedge clk);
    check($sformatf("%s idle req", tag), ibus_req_o, 1'b0);
    check($sformatf("%s idle stall", tag), fetch_stall_o, 1'b1);
    tick();
    for (int i = 0; i <= gd; i++) begin
      ibus_gnt_i = (i == gd);
      @(negedge clk);
      check($sformatf("%s req%0d req", tag, i), ibus_req_o, 1'b1);
      check($sformatf("%s req%0d addr", tag, i), ibus_addr_o, pc);
      check($sformatf("%s req%0d stall", tag, i), fetch_stall_o, 1'b1);
      check($sformatf("%s req%0d bubble", tag, i), inst_valid_o, 1'b0);
      tick();
    end
    ibus_gnt_i = 1'b0;
    for (int i = 1; i <= rd; i++) begin
      ibus_rvalid_i = (i == rd);
      ibus_rdata_i  = (i == rd) ? data : 32'h0;
      @(negedge clk);
      check($sformatf("%s wait%0d req", tag, i), ibus_req_o, 1'b0);
      check($sformatf("%s wait%0d stall", tag, i), fetch_stall_o, (i != rd));
      tick();
    end
    ibus_rvalid_i = 1'b0;
    check($sformatf("%s valid", tag), inst_valid_o, 1'b1);
    check($sformatf("%s inst", tag), inst_o, exp_inst);
    check($sformatf("%s addr", tag), inst_addr_o, exp_addr);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{pc: 32'h0,    rdata: 32'h0000_0297, gd: 0, rd: 1, hold: Hold_None,
                exp_inst: 32'h0000_0297, exp_addr: 32'h0};
    vecs[1] = '{pc: 32'h4,    rdata: 32'h0050_0093, gd: 2, rd: 3, hold: Hold_None,
                exp_inst: 32'h0050_0093, exp_addr: 32'h4};
    vecs[2] = '{pc: 32'h1000, rdata: 32'h0010_0313, gd: 1, rd: 1, hold: Hold_Pc,
                exp_inst: 32'h0010_0313, exp_addr: 32'h1000};
    vecs[3] = '{pc: 32'h1004, rdata: 32'h0020_8233, gd: 0, rd: 2, hold: Hold_Pc,
                exp_inst: 32'h0020_8233, exp_addr: 32'h1004};

    // Reset held for three cycles.
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("reset%0d valid", i), inst_valid_o, 1'b0);
      check($sformatf("reset%0d inst", i), inst_o, NOP);
      check($sformatf("reset%0d req", i), ibus_req_o, 1'b0);
      check($sformatf("reset%0d busaddr", i), ibus_addr_o, 32'h0);
    end
    rst = 1'b0;

    for (int i = 0; i < 4; i++) begin
      do_fetch($sformatf("vec%0d", i), vecs[i].pc, vecs[i].rdata, vecs[i].gd, vecs[i].rd,
               vecs[i].hold, vecs[i].exp_inst, vecs[i].exp_addr);
    end
    hold_flag_i = Hold_None;

    // Jump while 0x8 is outstanding: its late response must be discarded.
    pc_i = 32'h8;
    tick();
    ibus_gnt_i = 1'b1;
    @(negedge clk);
    check("jmp req addr", ibus_addr_o, 32'h8);
    tick();
    ibus_gnt_i  = 1'b0;
    jump_flag_i = 1'b1;
    @(negedge clk);
    check("jmp stall", fetch_stall_o, 1'b1);
    tick();
    jump_flag_i = 1'b0;
    pc_i        = 32'h100;
    check("jmp bubble valid", inst_valid_o, 1'b0);
    check("jmp bubble inst", inst_o, NOP);
    ibus_rvalid_i = 1'b1;
    ibus_rdata_i  = 32'hdead_beef;
    @(negedge clk);
    check("jmp late rsp stall", fetch_stall_o, 1'b1);
    tick();
    ibus_rvalid_i = 1'b0;
    check("jmp drop valid", inst_valid_o, 1'b0);
    check("jmp drop inst", inst_o, NOP);
    check("jmp refetch req", ibus_req_o, 1'b1);
    check("jmp refetch addr", ibus_addr_o, 32'h100);
    ibus_gnt_i = 1'b1;
    tick();
    ibus_gnt_i    = 1'b0;
    ibus_rvalid_i = 1'b1;
    ibus_rdata_i  = 32'h00a0_0113;
    @(negedge clk);
    check("jmp target stall", fetch_stall_o, 1'b0);
    tick();
    ibus_rvalid_i = 1'b0;
    check("jmp target valid", inst_valid_o, 1'b1);
    check("jmp target inst", inst_o, 32'h00a0_0113);
    check("jmp target addr", inst_addr_o, 32'h100);

    // Hold_If for four cycles with the response for 0x104 landing in the second.
    pc_i = 32'h104;
    tick();
    ibus_gnt_i = 1'b1;
    tick();
    ibus_gnt_i  = 1'b0;
    hold_flag_i = Hold_If;
    for (int i = 0; i < 4; i++) begin
      ibus_rvalid_i = (i == 1);
      ibus_rdata_i  = 32'h00c0_0193;
      @(negedge clk);
      check($sformatf("hold%0d req", i), ibus_req_o, 1'b0);
      check($sformatf("hold%0d stall", i), fetch_stall_o, 1'b1);
      tick();
      check($sformatf("hold%0d frozen valid", i), inst_valid_o, 1'b0);
      check($sformatf("hold%0d frozen addr", i), inst_addr_o, 32'h100);
    end
    ibus_rvalid_i = 1'b0;
    hold_flag_i   = Hold_Pc;
    @(negedge clk);
    check("unhold req", ibus_req_o, 1'b0);
    check("unhold stall", fetch_stall_o, 1'b0);
    tick();
    check("unhold valid", inst_valid_o, 1'b1);
    check("unhold inst", inst_o, 32'h00c0_0193);
    check("unhold addr", inst_addr_o, 32'h104);
    hold_flag_i = Hold_None;

    // Jump and hold together while the skid buffer is full: the flush wins.
    pc_i = 32'h108;
    tick();
    ibus_gnt_i = 1'b1;
    tick();
    ibus_gnt_i    = 1'b0;
    hold_flag_i   = Hold_If;
    ibus_rvalid_i = 1'b1;
    ibus_rdata_i  = 32'h0ff0_0213;
    tick();
    ibus_rvalid_i = 1'b0;
    jump_flag_i   = 1'b1;
    @(negedge clk);
    check("jmphold stall", fetch_stall_o, 1'b1);
    tick();
    jump_flag_i = 1'b0;
    hold_flag_i = Hold_None;
    check("jmphold valid", inst_valid_o, 1'b0);
    check("jmphold inst", inst_o, NOP);
    do_fetch("postflush", 32'h200, 32'h0000_0517, 0, 1, Hold_None, 32'h0000_0517, 32'h200);

    // Reset during WAIT: the orphaned response after reset is ignored.
    pc_i = 32'h204;
    tick();
    ibus_gnt_i = 1'b1;
    tick();
    ibus_gnt_i = 1'b0;
    rst        = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst valid", inst_valid_o, 1'b0);
    check("midrst inst", inst_o, NOP);
    check("midrst inst addr", inst_addr_o, 32'h0);
    check("midrst req", ibus_req_o, 1'b0);
    pc_i          = 32'h300;
    ibus_rvalid_i = 1'b1;
    ibus_rdata_i  = 32'hdead_beef;
    @(negedge clk);
    check("midrst stale stall", fetch_stall_o, 1'b1);
    tick();
    ibus_rvalid_i = 1'b0;
    check("midrst req after", ibus_req_o, 1'b1);
    check("midrst addr after", ibus_addr_o, 32'h300);
    ibus_gnt_i = 1'b1;
    tick();
    ibus_gnt_i    = 1'b0;
    ibus_rvalid_i = 1'b1;
    ibus_rdata_i  = 32'h0040_0293;
    @(negedge clk);
    check("midrst rsp stall", fetch_stall_o, 1'b0);
    tick();
    ibus_rvalid_i = 1'b0;
    check("midrst valid after", inst_valid_o, 1'b1);
    check("midrst inst after", inst_o, 32'h0040_0293);
    check("midrst inst addr after", inst_addr_o, 32'h300);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
